// File: rtl/puzzle_regfile_stk_if.sv
// Bus bundle between the search sequencer and the checkpointed register file.
// Master drives addresses, write and stack controls; slave returns reads and status.
interface puzzle_regfile_stk_if #(
  parameter int DATA_W    = 64,
  parameter int NREG      = 16,
  parameter int STK_DEPTH = 32
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(STK_DEPTH);

  logic [AW-1:0]     src0;
  logic [AW-1:0]     src1;
  logic [AW-1:0]     dst;
  logic              we;
  logic [DATA_W-1:0] data;
  logic              push;
  logic              pop;
  logic              err_clr;

  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              comp;
  logic [DATA_W-1:0] ord;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] mvd;
  logic [SW:0]       sp;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;

  modport master (
    output src0, src1, dst, we, data,
    output push, pop, err_clr,
    input  data0, data1, comp,
    input  ord, cnt, mvd,
    input  sp, full, empty, ovf, udf
  );

  modport slave (
    input  src0, src1, dst, we, data,
    input  push, pop, err_clr,
    output data0, data1, comp,
    output ord, cnt, mvd,
    output sp, full, empty, ovf, udf
  );
endinterface

// File: rtl/puzzle_regfile_stk.sv
// Solver register file with a one-cycle checkpoint stack for regs 1..4.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module puzzle_regfile_stk #(
  parameter int DATA_W    = 64,
  parameter int NREG      = 16,
  parameter int STK_DEPTH = 32,
  parameter logic [DATA_W-1:0] BRD_INIT =
    64'h5_0000_568_0_297_0_314,
  parameter logic [DATA_W-1:0] CLR_PAT =
    64'h9_0000_987_0_654_0_321
) (
  input logic               clk,
  input logic               rst_n,
  puzzle_regfile_stk_if.slave io
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(STK_DEPTH);
  localparam int EW = 4 * DATA_W;
  localparam logic [SW:0] SP_MAX = (SW+1)'(STK_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_OVF,
    OP_UDF
  } op_e;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [EW-1:0]     r_stk  [STK_DEPTH];
  logic [SW:0]       r_sp;
  logic              r_ovf;
  logic              r_udf;

  op_e               w_op;
  logic              w_full;
  logic              w_empty;
  logic [SW-1:0]     w_top_idx;
  logic [SW-1:0]     w_wr_idx;
  logic [EW-1:0]     w_top;
  logic [EW-1:0]     w_snap;
  logic [DATA_W-1:0] w_data0;
  logic [DATA_W-1:0] w_data1;
  logic [DATA_W-1:0] w_ord;
  logic [DATA_W-1:0] w_cnt;
  logic [DATA_W-1:0] w_mvd;

  assign w_full    = (r_sp == SP_MAX);
  assign w_empty   = (r_sp == '0);
  assign w_wr_idx  = r_sp[SW-1:0];
  assign w_top_idx = w_wr_idx - 1'b1;
  assign w_top     = r_stk[w_top_idx];
  assign w_snap    = {r_regs[4], r_regs[3],
                      r_regs[2], r_regs[1]};

  // push&pop together is an overflow-class error.
  always_comb begin
    w_op = OP_NONE;
    priority case (1'b1)
      (io.push && io.pop): w_op = OP_OVF;
      (io.push && w_full): w_op = OP_OVF;
      io.push:             w_op = OP_PUSH;
      (io.pop && w_empty): w_op = OP_UDF;
      io.pop:              w_op = OP_POP;
      default:             w_op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 1)
          r_regs[i] <= BRD_INIT;
        else if (i == 6)
          r_regs[i] <= DATA_W'(1);
        else
          r_regs[i] <= '0;
      end
    end else begin
      if (w_op == OP_POP) begin
        r_regs[1] <= w_top[0*DATA_W +: DATA_W];
        r_regs[2] <= w_top[1*DATA_W +: DATA_W];
        r_regs[3] <= w_top[2*DATA_W +: DATA_W];
        r_regs[4] <= w_top[3*DATA_W +: DATA_W];
      end
      if (io.we)
        r_regs[io.dst] <= io.data;
    end
  end

  // Stack RAM is not reset; rst_n only blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && w_op == OP_PUSH)
      r_stk[w_wr_idx] <= w_snap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_op == OP_PUSH)
        r_sp <= r_sp + 1'b1;
      else if (w_op == OP_POP)
        r_sp <= r_sp - 1'b1;

      if (w_op == OP_OVF)
        r_ovf <= 1'b1;
      else if (io.err_clr)
        r_ovf <= 1'b0;

      if (w_op == OP_UDF)
        r_udf <= 1'b1;
      else if (io.err_clr)
        r_udf <= 1'b0;
    end
  end

  always_comb begin
    w_data0 = r_regs[io.src0];
    w_data1 = r_regs[io.src1];
    w_ord   = r_regs[2];
    w_cnt   = r_regs[3];
    w_mvd   = r_regs[4];
`ifdef REGFILE_BYPASS_EN
    if (io.we) begin
      if (io.dst == io.src0)   w_data0 = io.data;
      if (io.dst == io.src1)   w_data1 = io.data;
      if (io.dst == AW'(2))    w_ord   = io.data;
      if (io.dst == AW'(3))    w_cnt   = io.data;
      if (io.dst == AW'(4))    w_mvd   = io.data;
    end
`endif
  end

  assign io.data0 = w_data0;
  assign io.data1 = w_data1;
  assign io.ord   = w_ord;
  assign io.cnt   = w_cnt;
  assign io.mvd   = w_mvd;
  assign io.comp  = (r_regs[1] == CLR_PAT);
  assign io.sp    = r_sp;
  assign io.full  = w_full;
  assign io.empty = w_empty;
  assign io.ovf   = r_ovf;
  assign io.udf   = r_udf;

endmodule

// File: tb/tb_puzzle_regfile_stk.sv
// Directed bench for puzzle_regfile_stk.
// Reset, write/read, checkpoint round trip, collisions, full/empty errors.
module tb_puzzle_regfile_stk;
  localparam logic [63:0] BRD = 64'h5_0000_568_0_297_0_314;
  localparam logic [63:0] CLR = 64'h9_0000_987_0_654_0_321;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  puzzle_regfile_stk_if #(
    .DATA_W(64), .NREG(16), .STK_DEPTH(32)
  ) bus ();

  puzzle_regfile_stk #(
    .DATA_W(64), .NREG(16), .STK_DEPTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d,
                    input logic [63:0] v);
    bus.we   = 1'b1;
    bus.dst  = d;
    bus.data = v;
    tick();
    bus.we   = 1'b0;
  endtask

  initial begin
    bus.src0 = 4'd1;
    bus.src1 = 4'd0;
    bus.dst = 4'd0;
    bus.we = 1'b0;
    bus.data = '0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.err_clr = 1'b0;

    // async reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_reg1", bus.data0, BRD);
    bus.src0 = 4'd6;
    #1;
    check("rst_reg6", bus.data0, 64'd1);
    check("rst_sp", 64'(bus.sp), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_comp", 64'(bus.comp), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_udf", 64'(bus.udf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write / read
    bus.src1 = 4'd3;
    bus.we = 1'b1;
    bus.dst = 4'd3;
    bus.data = 64'h2A;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_cycle_d1", bus.data1, 64'h2A);
`else
    check("wr_cycle_d1", bus.data1, 64'h0);
`endif
    tick();
    bus.we = 1'b0;
    check("wr_cnt", bus.cnt, 64'h2A);
    check("wr_d1", bus.data1, 64'h2A);

    // checkpoint round trip
    bus.src0 = 4'd1;
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
    check("rt_sp1", 64'(bus.sp), 64'd1);
    check("rt_nempty", 64'(bus.empty), 64'd0);
    wr(4'd1, CLR);
    wr(4'd2, 64'd7);
    check("rt_comp1", 64'(bus.comp), 64'd1);
    check("rt_ord7", bus.ord, 64'd7);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("rt_reg1", bus.data0, BRD);
    check("rt_ord0", bus.ord, 64'd0);
    check("rt_cnt", bus.cnt, 64'h2A);
    check("rt_comp0", 64'(bus.comp), 64'd0);
    check("rt_sp0", 64'(bus.sp), 64'd0);

    // pop with write collision on reg3
    wr(4'd3, 64'd5);
    wr(4'd4, 64'h44);
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
    wr(4'd3, 64'd9);
    wr(4'd4, 64'h55);
    wr(4'd1, CLR);
    bus.pop = 1'b1;
    bus.we = 1'b1;
    bus.dst = 4'd3;
    bus.data = 64'd12;
    tick();
    bus.pop = 1'b0;
    bus.we = 1'b0;
    check("col_cnt", bus.cnt, 64'd12);
    check("col_mvd", bus.mvd, 64'h44);
    check("col_ord", bus.ord, 64'd0);
    check("col_reg1", bus.data0, BRD);
    check("col_sp", 64'(bus.sp), 64'd0);

    // fill; same-cycle write to reg2 is not captured
    for (int i = 0; i < 32; i++) begin
      bus.push = 1'b1;
      bus.we = 1'b1;
      bus.dst = 4'd2;
      bus.data = 64'(i + 1);
      tick();
    end
    bus.push = 1'b0;
    bus.we = 1'b0;
    check("full_sp", 64'(bus.sp), 64'd32);
    check("full_flag", 64'(bus.full), 64'd1);
    check("full_ovf0", 64'(bus.ovf), 64'd0);
    check("full_ord", bus.ord, 64'd32);
    bus.push = 1'b1;
    bus.we = 1'b1;
    bus.dst = 4'd2;
    bus.data = 64'd99;
    tick();
    bus.push = 1'b0;
    bus.we = 1'b0;
    check("ovf_sp", 64'(bus.sp), 64'd32);
    check("ovf_flag", 64'(bus.ovf), 64'd1);
    check("ovf_wr", bus.ord, 64'd99);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("top_ord", bus.ord, 64'd31);
    check("top_cnt", bus.cnt, 64'd12);
    check("top_sp", 64'(bus.sp), 64'd31);
    check("top_nfull", 64'(bus.full), 64'd0);
    check("ovf_sticky", 64'(bus.ovf), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    check("clr_ovf", 64'(bus.ovf), 64'd0);
    bus.push = 1'b1;
    bus.pop = 1'b1;
    tick();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    check("setwin_ovf", 64'(bus.ovf), 64'd1);
    check("setwin_sp", 64'(bus.sp), 64'd31);
    tick();
    bus.err_clr = 1'b0;
    check("clr2_ovf", 64'(bus.ovf), 64'd0);

    // underflow and conflict after async reset
    rst_n = 1'b0;
    #1;
    check("rst2_sp", 64'(bus.sp), 64'd0);
    check("rst2_ord", bus.ord, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(4'd2, 64'd5);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("udf_flag", 64'(bus.udf), 64'd1);
    check("udf_ord", bus.ord, 64'd5);
    check("udf_sp", 64'(bus.sp), 64'd0);
    check("udf_empty", 64'(bus.empty), 64'd1);
    bus.push = 1'b1;
    repeat (3) tick();
    bus.pop = 1'b1;
    tick();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    check("conf_sp", 64'(bus.sp), 64'd3);
    check("conf_ovf", 64'(bus.ovf), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr3_ovf", 64'(bus.ovf), 64'd0);
    check("clr3_udf", 64'(bus.udf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
